// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner.
//   state_t  : scanner FSM states (scan, debounce, pressed, release)
//   ROW0     : first row-select pattern; rows are active-low, one low at a time
//   key_code : row-select pattern + synchronised columns -> {row[1:0], col[1:0]}
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } state_t;

  localparam logic [3:0] ROW0 = 4'b1110;

  // Lowest-index low column wins when several keys in one row are down.
  function automatic logic [3:0] key_code(input logic [3:0] row, input logic [3:0] col);
    logic [1:0] r;
    logic [1:0] c;
    r = '0;
    c = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!row[i]) r = 2'(i);
    end
    for (int unsigned i = 4; i > 0; i--) begin
      if (!col[i-1]) c = 2'(i - 1);
    end
    return {r, c};
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for the asynchronous, active-low keypad column bus.
//   clk_in : system clock
//   reset  : asynchronous active-high reset (flops go to all-high = no key)
//   i_col  : raw column pins
//   o_col  : synchronised columns, two cycles behind the pins
module keypad_sync (
  input  logic       clk_in,
  input  logic       reset,
  input  logic [3:0] i_col,
  output logic [3:0] o_col
);

  logic [3:0] col_meta;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      col_meta <= '1;
      o_col    <= '1;
    end else begin
      col_meta <= i_col;
      o_col    <= col_meta;
    end
  end

endmodule

// File: rtl/keypad_scan16.sv
// 4x4 matrix keypad scanner. Drives one row low at a time, samples the
// synchronised columns once per SCAN_DIV cycles, debounces press and release,
// and shifts each accepted key into a 32-bit hex entry register.
//   clk_in      : system clock (only clock)
//   reset       : asynchronous active-high reset
//   i_col       : keypad columns, active-low, asynchronous
//   o_row       : keypad rows, active-low, exactly one low
//   o_key_code  : last accepted key {row, col}
//   o_key_valid : one-cycle pulse per accepted key
//   o_value     : hex entry register, newest digit in [3:0]
//   o_busy      : FSM is outside the scan state
module keypad_scan16
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [3:0]  i_col,
  output logic [3:0]  o_row,
  output logic [3:0]  o_key_code,
  output logic        o_key_valid,
  output logic [31:0] o_value,
  output logic        o_busy
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned DB_W  = $clog2(DEBOUNCE + 1);

  logic [3:0]       col_sync;
  logic [DIV_W-1:0] div_cnt;
  logic             strobe;
  logic [DB_W-1:0]  db_cnt;
  logic [DB_W-1:0]  db_next;
  logic [3:0]       cand;
  logic [3:0]       cur_code;
  logic             no_key;
  logic             match;
  state_t           state;

  keypad_sync u_sync (
    .clk_in (clk_in),
    .reset  (reset),
    .i_col  (i_col),
    .o_col  (col_sync)
  );

  // Free-running: strobe spacing is independent of FSM state.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (strobe) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign strobe   = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign no_key   = &col_sync;
  assign cur_code = key_code(o_row, col_sync);
  assign match    = !no_key && (cur_code == cand);
  assign db_next  = db_cnt + 1'b1;

  // o_busy is updated alongside every state change so it stays registered.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state       <= ST_SCAN;
      o_row       <= ROW0;
      cand        <= '0;
      db_cnt      <= '0;
      o_key_code  <= '0;
      o_key_valid <= 1'b0;
      o_value     <= '0;
      o_busy      <= 1'b0;
    end else begin
      o_key_valid <= 1'b0;
      case (state)
        ST_SCAN: begin
          if (strobe) begin
            if (no_key) begin
              o_row <= {o_row[2:0], o_row[3]};
            end else begin
              cand   <= cur_code;
              db_cnt <= DB_W'(1);
              o_busy <= 1'b1;
              if (DEBOUNCE == 1) state <= ST_PRESSED;
              else               state <= ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (strobe) begin
            if (match) begin
              db_cnt <= db_next;
              if (db_next == DB_W'(DEBOUNCE)) state <= ST_PRESSED;
            end else begin
              // Row is left where it is; the next scan strobe re-samples it.
              db_cnt <= '0;
              state  <= ST_SCAN;
              o_busy <= 1'b0;
            end
          end
        end
        ST_PRESSED: begin
          o_key_valid <= 1'b1;
          o_key_code  <= cand;
          o_value     <= {o_value[27:0], cand};
          db_cnt      <= '0;
          state       <= ST_RELEASE;
        end
        ST_RELEASE: begin
          if (strobe) begin
            if (no_key) begin
              if (db_next == DB_W'(DEBOUNCE)) begin
                db_cnt <= '0;
                state  <= ST_SCAN;
                o_busy <= 1'b0;
              end else begin
                db_cnt <= db_next;
              end
            end else begin
              db_cnt <= '0;
            end
          end
        end
        default: begin
          state  <= ST_SCAN;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan16.sv
// Scoreboard bench for keypad_scan16 with a behavioural 4x4 keypad model.
module tb_keypad_scan16;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEBOUNCE = 3;

  logic        clk_in = 1'b0;
  logic        reset  = 1'b1;
  logic [3:0]  i_col;
  logic [3:0]  o_row;
  logic [3:0]  o_key_code;
  logic        o_key_valid;
  logic [31:0] o_value;
  logic        o_busy;

  always #5 clk_in = ~clk_in;

  keypad_scan16 #(
    .SCAN_DIV (SCAN_DIV),
    .DEBOUNCE (DEBOUNCE)
  ) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .i_col       (i_col),
    .o_row       (o_row),
    .o_key_code  (o_key_code),
    .o_key_valid (o_key_valid),
    .o_value     (o_value),
    .o_busy      (o_busy)
  );

  // Keypad: a pressed key at (r,c) pulls column c low while row r is driven low.
  logic [15:0] pressed;
  always_comb begin
    i_col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !o_row[r]) i_col[c] = 1'b0;
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_pulses = 0;
  logic [35:0] sb_q[$];
  logic [35:0] item;
  logic [31:0] exp_value;

  logic        bounce_phase = 1'b0;
  int          busy_run     = 0;
  int          busy_max     = 0;
  logic        busy_seen    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // Expected digit goes into the scoreboard before the key is touched.
  task automatic expect_key(input int r, input int c);
    logic [3:0] code;
    code      = 4'(r * 4 + c);
    exp_value = {exp_value[27:0], code};
    sb_q.push_back({code, exp_value});
  endtask

  task automatic press_key(input int r, input int c, input int hold);
    expect_key(r, c);
    pressed[r*4+c] = 1'b1;
    cycles(hold);
    pressed = '0;
    cycles(24);
  endtask

  // Monitor: every key_valid pulse is matched against the scoreboard.
  always @(negedge clk_in) begin
    if (!reset && o_key_valid) begin
      n_pulses++;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got code %h value %h, expected no pulse", o_key_code, o_value);
      end else begin
        item = sb_q.pop_front();
        check("key_code", {28'h0, o_key_code}, {28'h0, item[35:32]});
        check("value", o_value, item[31:0]);
      end
    end
    if (bounce_phase) begin
      if (o_busy) begin
        busy_run++;
        busy_seen = 1'b1;
        if (busy_run > busy_max) busy_max = busy_run;
      end else begin
        busy_run = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_row;
    int t;
    pressed   = '0;
    exp_value = '0;
    repeat (2) @(posedge clk_in);
    #1;

    // Reset values
    check("rst_row", {28'h0, o_row}, 32'hE);
    check("rst_code", {28'h0, o_key_code}, 32'h0);
    check("rst_valid", {31'h0, o_key_valid}, 32'h0);
    check("rst_value", o_value, 32'h0);
    check("rst_busy", {31'h0, o_busy}, 32'h0);

    // Idle scan: row advances after every 4th edge following reset release
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk_in);
      #1;
      exp_row = 4'hF;
      exp_row[(k / 4) % 4] = 1'b0;
      check("idle_row", {28'h0, o_row}, {28'h0, exp_row});
    end
    check("idle_value", o_value, 32'h0);

    // Single press row 2 col 1 -> 9
    press_key(2, 1, 40);
    check("single_value", o_value, 32'h00000009);

    // Bounce: align toggling to the start of row 2's dwell
    for (t = 0; t < 40 && o_row == 4'b1011; t++) cycles(1);
    for (t = 0; t < 40 && o_row != 4'b1011; t++) cycles(1);
    check("bounce_row_found", {28'h0, o_row}, 32'hB);
    bounce_phase = 1'b1;
    repeat (16) begin
      pressed[9] = ~pressed[9];
      cycles(4);
    end
    pressed = '0;
    cycles(16);
    bounce_phase = 1'b0;
    check("bounce_busy_seen", {31'h0, busy_seen}, 32'h1);
    check("bounce_busy_max_le4", {31'h0, (busy_max <= 4)}, 32'h1);
    check("bounce_value", o_value, 32'h00000009);

    // Nine digits 1..9
    for (int d = 1; d <= 9; d++) press_key(d / 4, d % 4, 40);
    check("nine_value", o_value, 32'h23456789);

    // Two keys in row 1: col 0 wins; no repeat while either stays down
    expect_key(1, 0);
    pressed[4] = 1'b1;
    pressed[7] = 1'b1;
    cycles(60);
    pressed[4] = 1'b0;
    cycles(30);
    pressed[7] = 1'b0;
    cycles(24);
    check("two_key_value", o_value, 32'h34567894);

    // Reset during debounce
    pressed[9] = 1'b1;
    for (t = 0; t < 40 && !o_busy; t++) cycles(1);
    check("busy_before_reset", {31'h0, o_busy}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_row", {28'h0, o_row}, 32'hE);
    check("mid_rst_code", {28'h0, o_key_code}, 32'h0);
    check("mid_rst_valid", {31'h0, o_key_valid}, 32'h0);
    check("mid_rst_value", o_value, 32'h0);
    check("mid_rst_busy", {31'h0, o_busy}, 32'h0);
    @(posedge clk_in);
    #1;
    reset     = 1'b0;
    exp_value = '0;
    expect_key(2, 1);
    cycles(40);
    pressed = '0;
    cycles(24);
    check("post_rst_value", o_value, 32'h00000009);

    // Totals
    check("pulse_count", n_pulses, 32'd12);
    check("scoreboard_empty", sb_q.size(), 32'd0);
    check("final_value", o_value, exp_value);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
